// File: rtl/tlb_op_unit.sv
// Joint TLB array with TLBP/TLBR/TLBWI/TLBWR execution and the CP0 Random register.
// Results are registered, so they appear one cycle after the op is sampled.
module tlb_op_unit #(
    parameter int NENTRIES = 16,
    parameter int IDXW     = $clog2(NENTRIES),
    parameter int PFNW     = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    input  logic [1:0]      op_code,
    input  logic [31:0]     entryhi_in,
    input  logic [31:0]     entrylo0_in,
    input  logic [31:0]     entrylo1_in,
    input  logic [31:0]     index_in,
    input  logic [IDXW-1:0] wired,
    input  logic            wired_wr,
    output logic            resp_valid,
    output logic [31:0]     resp_index,
    output logic [31:0]     resp_entryhi,
    output logic [31:0]     resp_entrylo0,
    output logic [31:0]     resp_entrylo1,
    output logic [31:0]     random_out
);

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWR = 2'd3;
    // Stored EntryLo payload is {pfn, c, d, v}; G is kept once per entry.
    localparam int LOW = PFNW + 5;
    localparam logic [IDXW-1:0] RAND_TOP = IDXW'(NENTRIES - 1);

    logic [18:0]     vpn2_q [NENTRIES];
    logic [7:0]      asid_q [NENTRIES];
    logic            g_q    [NENTRIES];
    logic [LOW-1:0]  lo0_q  [NENTRIES];
    logic [LOW-1:0]  lo1_q  [NENTRIES];
    logic [IDXW-1:0] random_q;

    logic            hit_p0;
    logic [IDXW-1:0] hit_idx_p0;
    logic [IDXW-1:0] rd_idx_p0;
    logic [IDXW-1:0] wr_idx_p0;
    logic            do_write_p0;

    logic unused_bits;
    assign unused_bits = ^{entryhi_in[12:8], index_in[31:IDXW],
                           entrylo0_in[31:LOW+1], entrylo1_in[31:LOW+1]};

    // Stage p0: probe search and target selection, all combinational on the issued op
    always_comb begin
        hit_p0     = 1'b0;
        hit_idx_p0 = '0;
        // Scanning downwards lets the lowest matching index win.
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (vpn2_q[i] == entryhi_in[31:13] &&
                (g_q[i] || asid_q[i] == entryhi_in[7:0])) begin
                hit_p0     = 1'b1;
                hit_idx_p0 = IDXW'(i);
            end
        end
    end

    assign rd_idx_p0   = index_in[IDXW-1:0];
    assign wr_idx_p0   = (op_code == OP_TLBWR) ? random_q : rd_idx_p0;
    assign do_write_p0 = op_valid && op_code[1];

    // Stage p1: array writes, registered responses and Random
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NENTRIES; i++) begin
                vpn2_q[i] <= '0;
                asid_q[i] <= '0;
                g_q[i]    <= 1'b0;
                lo0_q[i]  <= '0;
                lo1_q[i]  <= '0;
            end
        end else if (do_write_p0) begin
            vpn2_q[wr_idx_p0] <= entryhi_in[31:13];
            asid_q[wr_idx_p0] <= entryhi_in[7:0];
            g_q[wr_idx_p0]    <= entrylo0_in[0] & entrylo1_in[0];
            lo0_q[wr_idx_p0]  <= entrylo0_in[LOW:1];
            lo1_q[wr_idx_p0]  <= entrylo1_in[LOW:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid    <= 1'b0;
            resp_index    <= '0;
            resp_entryhi  <= '0;
            resp_entrylo0 <= '0;
            resp_entrylo1 <= '0;
        end else begin
            resp_valid <= op_valid && !op_code[1];
            if (op_valid && op_code == OP_TLBP) begin
                resp_index <= hit_p0 ? 32'(hit_idx_p0) : 32'h8000_0000;
            end
            if (op_valid && op_code == OP_TLBR) begin
                resp_entryhi  <= {vpn2_q[rd_idx_p0], 5'b0, asid_q[rd_idx_p0]};
                resp_entrylo0 <= 32'({lo0_q[rd_idx_p0], g_q[rd_idx_p0]});
                resp_entrylo1 <= 32'({lo1_q[rd_idx_p0], g_q[rd_idx_p0]});
            end
        end
    end

    // A Wired value at or above the top pins Random at the top.
    always_ff @(posedge clk) begin
        if (reset || wired_wr || random_q <= wired) begin
            random_q <= RAND_TOP;
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

    assign random_out = 32'(random_q);

endmodule
